instr_fetch_unit: RTL
=====================

Name: instr_fetch_unit

Overview:
Fetches AAP instruction halfwords from instruction memory and produces the 32-bit `fetchoutput` word that the decoder consumes.
- 16-bit instruction word w (w[15]=0) is presented as {w, 16'h0000}.
- 32-bit instruction (first halfword bit 15 = 1) is presented as {first, second}, so bit 31 marks 32-bit format.
- Block owns the PC, issues one memory request at a time, holds each instruction until the decode stage accepts it, and handles branch redirects.

Parameters:
- ADDR_W, 24, width of the halfword-granular code address / PC.
- RESET_PC, 0, PC value loaded on reset.

Ports:
- clock  in  1  system clock; all state updates on the rising edge.
- reset  in  1  synchronous, active-high reset.
- mem_req  out  1  one-cycle pulse requesting the halfword at mem_addr.
- mem_addr  out  ADDR_W  halfword address; valid when mem_req=1.
- mem_rdata  in  16  returned halfword; valid when mem_rvalid=1.
- mem_rvalid  in  1  response strobe; at least 1 cycle after mem_req; in-order.
- fetchoutput  out  32  assembled instruction for the decoder.
- fetch_valid  out  1  fetchoutput / fetch_pc / fetch_is32 are valid.
- fetch_pc  out  ADDR_W  address of the first halfword of the presented instruction.
- fetch_is32  out  1  presented instruction is 32-bit (equals fetchoutput[31]).
- decode_ready  in  1  decoder accepts the instruction this cycle when fetch_valid=1.
- branch_valid  in  1  redirect request, one cycle.
- branch_target  in  ADDR_W  new PC for the redirect.

Behaviour:
- Reset:
  - pc=RESET_PC, state=S_FIRST.
  - mem_req=0, mem_addr=RESET_PC, fetchoutput=0, fetch_valid=0, fetch_pc=0, fetch_is32=0.
  - outstanding=0, drop=0.
  - A response arriving during reset is ignored.
- All outputs are registered.
- At most one request outstanding.
- mem_req pulses for exactly one cycle when state is S_FIRST or S_SECOND, outstanding=0 and branch_valid=0. The same edge sets outstanding=1 and mem_addr=pc.
- A mem_rvalid clears outstanding. If drop=1, the data is discarded and drop clears. A mem_rvalid while outstanding=0 is ignored.
- S_FIRST, on accepted response w:
  - w[15]=0: fetchoutput={w,16'h0000}, fetch_is32=0, fetch_pc=pc, pc=pc+1, fetch_valid=1, go S_HOLD.
  - w[15]=1: hi=w, ipc=pc, pc=pc+1, go S_SECOND.
- S_SECOND, on accepted response w2: fetchoutput={hi,w2}, fetch_is32=1, fetch_pc=ipc, pc=pc+1, fetch_valid=1, go S_HOLD.
- S_HOLD:
  - Outputs are stable while decode_ready=0.
  - decode_ready=1: fetch_valid=0 next cycle, go S_FIRST.
  - No requests are issued in S_HOLD.
- Latency with 1-cycle memory: 16-bit instruction valid 2 cycles after mem_req; 32-bit valid 4 cycles after the first mem_req.
- Redirect (branch_valid=1, any state):
  - pc=branch_target, state=S_FIRST, fetch_valid=0 next cycle.
  - If outstanding=1 and no mem_rvalid that cycle, drop=1.
  - A response arriving in the same cycle as branch_valid is discarded.
  - The new request is issued only once outstanding=0.
- Priority: reset > branch_valid > response/decode_ready. branch_valid with decode_ready in S_HOLD counts as consumed; redirect wins.
- PC increments modulo 2^ADDR_W. A 32-bit instruction at address 2^ADDR_W-1 takes its second halfword from address 0.
- No exception or illegal-encoding detection; the decoder handles that.

Optional Feature:
- Macro: INSTR_FETCH_COUNT_EN.
- Defined: adds output port fetch_count (32 bits).
  - Reset to 0.
  - Increments by 1 on each cycle with fetch_valid=1 and decode_ready=1 and branch_valid=0.
  - Wraps at 2^32.
- Undefined: port and counter are absent; behaviour otherwise identical.

Decomposition:
- Package aap_fetch_pkg holds:
  - state encoding S_FIRST / S_SECOND / S_HOLD.
  - INSTR32_BIT=15.
  - HALF_W=16.
  - PAD16=16'h0000.
- No sub-module; a single flat module is natural.
- Counter stays inline under the macro.

Test Plan:
- Reset, memory returns 16'h1234 at 0 -> mem_req at addr 0; fetchoutput=32'h12340000, fetch_pc=0, fetch_is32=0; next request addr 1.
- Halfwords 16'h8A01 then 16'h00C3 at addr 5,6 -> one instruction fetchoutput=32'h8A0100C3, fetch_is32=1, fetch_pc=5; next request addr 7.
- decode_ready held 0 for 5 cycles -> outputs stable, no mem_req; decode_ready=1 -> fetch_valid=0 next cycle, request for next pc.
- branch_valid with target 24'h000100 while a request is outstanding, memory then returns 16'hFFFF -> 16'hFFFF discarded; next mem_req addr 24'h000100.
- PC=24'hFFFFFF, halfword 16'h8000 then 16'h0001 -> second request addr 0; fetchoutput=32'h80000001, fetch_pc=24'hFFFFFF.
- With INSTR_FETCH_COUNT_EN, 3 accepted instructions, one of them cancelled by a same-cycle branch -> fetch_count=2.

Source files
------------

// File: rtl/aap_fetch_pkg.sv
// Shared encodings for the AAP fetch unit: FSM states and halfword layout constants.
package aap_fetch_pkg;

    typedef enum logic [1:0] {
        S_FIRST  = 2'd0,
        S_SECOND = 2'd1,
        S_HOLD   = 2'd2
    } state_t;

    localparam int          INSTR32_BIT = 15;
    localparam int          HALF_W      = 16;
    localparam logic [15:0] PAD16       = 16'h0000;

endpackage

// File: rtl/instr_fetch_unit.sv
// AAP fetch: one halfword request in flight, assembles 16/32-bit words for decode; optional INSTR_FETCH_COUNT_EN counter.
// Latency 2 cycles (16-bit) / 4 cycles (32-bit) from first mem_req; holds the word until decode_ready, redirect wins.
module instr_fetch_unit
    import aap_fetch_pkg::*;
#(
    parameter int                ADDR_W   = 24,
    parameter logic [ADDR_W-1:0] RESET_PC = '0
) (
    input  logic              clock,
    input  logic              reset,
    output logic              mem_req,
    output logic [ADDR_W-1:0] mem_addr,
    input  logic [15:0]       mem_rdata,
    input  logic              mem_rvalid,
    output logic [31:0]       fetchoutput,
    output logic              fetch_valid,
    output logic [ADDR_W-1:0] fetch_pc,
    output logic              fetch_is32,
    input  logic              decode_ready,
    input  logic              branch_valid,
`ifdef INSTR_FETCH_COUNT_EN
    output logic [31:0]       fetch_count,
`endif
    input  logic [ADDR_W-1:0] branch_target
);

    state_t              state, state_nxt;
    logic [ADDR_W-1:0]   pc, pc_nxt, ipc, ipc_nxt, addr_nxt, fpc_nxt;
    logic [HALF_W-1:0]   hi, hi_nxt;
    logic [31:0]         out_nxt;
    logic                outstanding, outstanding_nxt, drop, drop_nxt;
    logic                req_nxt, valid_nxt, is32_nxt, accept;
    logic [ADDR_W-1:0]   pc_inc;

    assign accept = mem_rvalid && outstanding;
    assign pc_inc = pc + ADDR_W'(1);

    always_comb begin
        state_nxt       = state;
        pc_nxt          = pc;
        ipc_nxt         = ipc;
        hi_nxt          = hi;
        outstanding_nxt = outstanding;
        drop_nxt        = drop;
        req_nxt         = 1'b0;
        addr_nxt        = mem_addr;
        out_nxt         = fetchoutput;
        valid_nxt       = fetch_valid;
        fpc_nxt         = fetch_pc;
        is32_nxt        = fetch_is32;

        if (branch_valid) begin
            pc_nxt    = branch_target;
            state_nxt = S_FIRST;
            valid_nxt = 1'b0;
            if (accept) begin
                outstanding_nxt = 1'b0;
                drop_nxt        = 1'b0;
            end else if (outstanding) begin
                drop_nxt = 1'b1;
            end
        end else begin
            if (accept) begin
                outstanding_nxt = 1'b0;
                if (drop) begin
                    drop_nxt = 1'b0;
                end else if (state == S_FIRST) begin
                    pc_nxt = pc_inc;
                    if (!mem_rdata[INSTR32_BIT]) begin
                        out_nxt   = {mem_rdata, PAD16};
                        is32_nxt  = 1'b0;
                        fpc_nxt   = pc;
                        valid_nxt = 1'b1;
                        state_nxt = S_HOLD;
                    end else begin
                        // Chain the second-halfword request on the same edge to keep 32-bit latency at 4.
                        hi_nxt          = mem_rdata;
                        ipc_nxt         = pc;
                        state_nxt       = S_SECOND;
                        req_nxt         = 1'b1;
                        addr_nxt        = pc_inc;
                        outstanding_nxt = 1'b1;
                    end
                end else if (state == S_SECOND) begin
                    out_nxt   = {hi, mem_rdata};
                    is32_nxt  = 1'b1;
                    fpc_nxt   = ipc;
                    pc_nxt    = pc_inc;
                    valid_nxt = 1'b1;
                    state_nxt = S_HOLD;
                end
            end else if (!outstanding && state != S_HOLD) begin
                req_nxt         = 1'b1;
                addr_nxt        = pc;
                outstanding_nxt = 1'b1;
            end
            if (state == S_HOLD && decode_ready) begin
                valid_nxt = 1'b0;
                state_nxt = S_FIRST;
            end
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state       <= S_FIRST;
            pc          <= RESET_PC;
            ipc         <= '0;
            hi          <= '0;
            outstanding <= 1'b0;
            drop        <= 1'b0;
            mem_req     <= 1'b0;
            mem_addr    <= RESET_PC;
            fetchoutput <= '0;
            fetch_valid <= 1'b0;
            fetch_pc    <= '0;
            fetch_is32  <= 1'b0;
        end else begin
            state       <= state_nxt;
            pc          <= pc_nxt;
            ipc         <= ipc_nxt;
            hi          <= hi_nxt;
            outstanding <= outstanding_nxt;
            drop        <= drop_nxt;
            mem_req     <= req_nxt;
            mem_addr    <= addr_nxt;
            fetchoutput <= out_nxt;
            fetch_valid <= valid_nxt;
            fetch_pc    <= fpc_nxt;
            fetch_is32  <= is32_nxt;
        end
    end

`ifdef INSTR_FETCH_COUNT_EN
    always_ff @(posedge clock) begin
        if (reset) begin
            fetch_count <= '0;
        end else if (fetch_valid && decode_ready && !branch_valid) begin
            fetch_count <= fetch_count + 32'd1;
        end
    end
`endif

endmodule
